// File: rtl/tiny_fpga_pkg.sv
// Shared sizes, configuration layout and LUT helper for the tiny FPGA fabric.
package tiny_fpga_pkg;

  localparam int NUM_LE       = 8;
  localparam int LUT_K        = 4;
  localparam int SRC_W        = 4;
  localparam int LE_CFG_W     = 33;
  localparam int OUT_SEL_W    = 3;
  localparam int NUM_IO       = 8;
  localparam int CFG_W        = 296;
  localparam int NUM_SRC      = 1 << SRC_W;

  localparam int LE_BASE      = 0;
  localparam int OUT_SEL_BASE = 264;
  localparam int OE_BASE      = 288;

  // Field order mirrors the bitstream: truth table in the low bits, sel3 on top.
  typedef struct packed {
    logic [SRC_W-1:0]      sel3;
    logic [SRC_W-1:0]      sel2;
    logic [SRC_W-1:0]      sel1;
    logic [SRC_W-1:0]      sel0;
    logic                  reg_en;
    logic [(1<<LUT_K)-1:0] truth;
  } le_cfg_t;

  function automatic int le_base(input int idx);
    return LE_BASE + idx * LE_CFG_W;
  endfunction

  function automatic logic lut_eval(input le_cfg_t c, input logic [NUM_SRC-1:0] src);
    logic [LUT_K-1:0] idx;
    idx = {src[c.sel3], src[c.sel2], src[c.sel1], src[c.sel0]};
    return c.truth[idx];
  endfunction

endpackage

// File: rtl/tiny_fpga_le.sv
// One logic element: four source muxes, a 2^K-entry LUT and an optional output flop.
module tiny_fpga_le
  import tiny_fpga_pkg::*;
#(
  parameter int K = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  le_cfg_t            cfg_i,
  input  logic [NUM_SRC-1:0] src_i,
  output logic               q_o,
  output logic               out_o
);

  logic         in0, in1, in2, in3;
  logic [K-1:0] idx;
  logic         lut_d;
  logic         q_q;

  assign in0   = src_i[cfg_i.sel0];
  assign in1   = src_i[cfg_i.sel1];
  assign in2   = src_i[cfg_i.sel2];
  assign in3   = src_i[cfg_i.sel3];
  assign idx   = {in3, in2, in1, in0};
  assign lut_d = cfg_i.truth[idx];

  // The flop tracks the LUT every cycle; reg_en only chooses which value leaves the LE.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      q_q <= 1'b0;
    end else begin
      q_q <= lut_d;
    end
  end

  assign q_o   = q_q;
  assign out_o = cfg_i.reg_en ? q_q : lut_d;

endmodule

// File: rtl/tt_um_riceshelley_tiny_fpga.sv
// Tiny FPGA: 8 LUT4 logic elements programmed through a 296-bit scan chain.
// Programming pins are resynchronised to clk; fabric outputs are muted while programming.
module tt_um_riceshelley_tiny_fpga #(
  parameter int NUM_LE = tiny_fpga_pkg::NUM_LE,
  parameter int LUT_K  = tiny_fpga_pkg::LUT_K,
  parameter int CFG_W  = tiny_fpga_pkg::CFG_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);
  import tiny_fpga_pkg::*;

  localparam int SY_CLK = 0;
  localparam int SY_EN  = 1;
  localparam int SY_DAT = 2;

  logic             prog_rst;
  logic [2:0]       sync_pin;
  logic [2:0]       sync1_q, sync2_q;
  logic             pclk_prev_q;
  logic             prog_en;
  logic             shift_en;
  logic [CFG_W-1:0] cfg_q, cfg_d;

  le_cfg_t          le_cfg [NUM_LE];
  logic [NUM_LE-1:0] le_reg;
  logic [NUM_LE-1:0] le_q;
  logic [NUM_LE-1:0] le_out;
  logic [NUM_LE-1:0] fb_cur, fb_nxt;

  logic unused_ok;
  assign unused_ok = &{1'b0, rst_n, ena, ui_in[7:4]};

  assign prog_rst = ui_in[1];
  assign sync_pin = {ui_in[3], ui_in[2], ui_in[0]};
  assign prog_en  = sync2_q[SY_EN];
  assign shift_en = sync2_q[SY_CLK] & ~pclk_prev_q & prog_en;
  assign cfg_d    = shift_en ? {sync2_q[SY_DAT], cfg_q[CFG_W-1:1]} : cfg_q;

  always_ff @(posedge clk) begin
    if (prog_rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      pclk_prev_q <= 1'b0;
      cfg_q       <= '0;
    end else begin
      sync1_q     <= sync_pin;
      sync2_q     <= sync1_q;
      pclk_prev_q <= sync2_q[SY_CLK];
      cfg_q       <= cfg_d;
    end
  end

  assign uo_out = {7'b0, cfg_q[0]};

  // Combinational LE-to-LE chains are resolved by repeated evaluation rather than a
  // structural loop: registered LEs seed the feedback, and each pass fixes one more
  // level of a chain. NUM_LE-1 passes here plus the LE instances cover the longest
  // legal chain; an illegal loop only yields garbage fabric outputs.
  always_comb begin
    fb_cur = le_q & le_reg;
    fb_nxt = fb_cur;
    for (int s = 0; s < NUM_LE - 1; s++) begin
      for (int i = 0; i < NUM_LE; i++) begin
        fb_nxt[i] = le_reg[i] ? le_q[i] : lut_eval(le_cfg[i], {fb_cur, uio_in});
      end
      fb_cur = fb_nxt;
    end
  end

  for (genvar i = 0; i < NUM_LE; i++) begin : g_le
    assign le_cfg[i] = le_cfg_t'(cfg_q[le_base(i) +: LE_CFG_W]);
    assign le_reg[i] = le_cfg[i].reg_en;

    tiny_fpga_le #(
      .K(LUT_K)
    ) u_le (
      .clk_i (clk),
      .rst_i (prog_rst),
      .clr_i (prog_en),
      .cfg_i (le_cfg[i]),
      .src_i ({fb_cur, uio_in}),
      .q_o   (le_q[i]),
      .out_o (le_out[i])
    );
  end

  always_comb begin
    uio_out = '0;
    uio_oe  = '0;
    if (!prog_en) begin
      for (int j = 0; j < NUM_IO; j++) begin
        uio_out[j] = le_out[cfg_q[OUT_SEL_BASE + OUT_SEL_W * j +: OUT_SEL_W]];
      end
      uio_oe = cfg_q[OE_BASE +: NUM_IO];
    end
  end

endmodule

// File: tb/tb_tt_um_riceshelley_tiny_fpga.sv
// Directed bench for the tiny FPGA: reset, scan readback, AND4 chain, toggle flop, progEn/progClk corners.
module tb_tt_um_riceshelley_tiny_fpga;

  localparam int CW = 296;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_vec = 0;
  int n_bad = 0;

  logic [CW-1:0] pat, rb, exp_cfg, and4_cfg, tog_cfg;

  always #5 clk = ~clk;

  tt_um_riceshelley_tiny_fpga dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_cfg(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit: progClk high for 3 clk (shift lands on the 3rd edge), then low for 2.
  task automatic shift_bit(input logic b);
    ui_in[3] = b;
    ui_in[2] = 1'b1;
    ui_in[0] = 1'b1;
    tick(3);
    ui_in[0] = 1'b0;
    tick(2);
  endtask

  task automatic load(input logic [CW-1:0] c);
    for (int k = 0; k < CW; k++) shift_bit(c[k]);
  endtask

  task automatic readback(output logic [CW-1:0] v);
    v = '0;
    for (int k = 0; k < CW; k++) begin
      v[k] = uo_out[0];
      shift_bit(1'b0);
    end
  endtask

  task automatic run_mode();
    ui_in[2] = 1'b0;
    ui_in[0] = 1'b0;
    ui_in[3] = 1'b0;
  endtask

  function automatic logic [CW-1:0] with_le(input logic [CW-1:0] c, input int i,
                                            input logic [15:0] tt, input logic r,
                                            input logic [3:0] s0, input logic [3:0] s1,
                                            input logic [3:0] s2, input logic [3:0] s3);
    logic [CW-1:0] v;
    v = c;
    v[33*i +: 33] = {s3, s2, s1, s0, r, tt};
    return v;
  endfunction

  function automatic logic [CW-1:0] with_pin(input logic [CW-1:0] c, input int j, input logic [2:0] le);
    logic [CW-1:0] v;
    v = c;
    v[264 + 3*j +: 3] = le;
    return v;
  endfunction

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h02;
    uio_in = 8'h00;
    tick(2);
    ui_in[1] = 1'b0;
    tick(1);
    check8("rst_uo_out", uo_out, 8'h00);
    check8("rst_uio_out", uio_out, 8'h00);
    check8("rst_uio_oe", uio_oe, 8'h00);

    readback(rb);
    check_cfg("rst_readback", rb, '0);

    // Scan chain FIFO order with a random pattern.
    for (int k = 0; k < CW; k++) pat[k] = 1'($urandom_range(0, 1));
    load(pat);
    readback(rb);
    check_cfg("scan_readback", rb, pat);

    // AND4 on LE0, LE1 = NOT LE0 through a combinational chain.
    and4_cfg = '0;
    and4_cfg = with_le(and4_cfg, 0, 16'h8000, 1'b0, 4'd0, 4'd1, 4'd2, 4'd3);
    and4_cfg = with_le(and4_cfg, 1, 16'h5555, 1'b0, 4'd8, 4'd8, 4'd8, 4'd8);
    and4_cfg = with_pin(and4_cfg, 0, 3'd0);
    and4_cfg = with_pin(and4_cfg, 1, 3'd1);
    for (int j = 2; j < 8; j++) and4_cfg = with_pin(and4_cfg, j, 3'd2);
    and4_cfg[288 +: 8] = 8'h01;
    load(and4_cfg);
    run_mode();
    tick(3);
    uio_in = 8'h0F; tick(1);
    check8("and4_0f_out", uio_out, 8'h01);
    check8("and4_oe", uio_oe, 8'h01);
    uio_in = 8'h07; tick(1);
    check8("and4_07_out", uio_out, 8'h02);
    uio_in = 8'hFF; tick(1);
    check8("and4_ff_out", uio_out, 8'h01);
    uio_in = 8'h0E; tick(1);
    check8("and4_0e_out", uio_out, 8'h02);

    // Partial bitstream then reset held across two shifts: everything discarded.
    for (int k = 0; k < 100; k++) shift_bit(1'b1);
    ui_in[1] = 1'b1;
    shift_bit(1'b1);
    shift_bit(1'b1);
    ui_in[1] = 1'b0;
    tick(1);
    run_mode();
    tick(3);
    uio_in = 8'h0F; tick(1);
    check8("midrst_uio_out", uio_out, 8'h00);
    check8("midrst_uio_oe", uio_oe, 8'h00);
    readback(rb);
    check_cfg("midrst_readback", rb, '0);

    // Toggle flop: LE0 registered, fed from itself, inverting.
    tog_cfg = '0;
    tog_cfg = with_le(tog_cfg, 0, 16'h5555, 1'b1, 4'd8, 4'd8, 4'd8, 4'd8);
    for (int j = 1; j < 8; j++) tog_cfg = with_pin(tog_cfg, j, 3'd1);
    tog_cfg[288 +: 8] = 8'h01;
    load(tog_cfg);
    run_mode();
    tick(1);
    check8("tog_still_muted", uio_oe, 8'h00);
    tick(1);
    check8("tog_first", uio_out, 8'h00);
    check8("tog_oe", uio_oe, 8'h01);
    tick(1);
    check8("tog_c1", uio_out, 8'h01);
    tick(1);
    check8("tog_c2", uio_out, 8'h00);
    tick(1);
    check8("tog_c3", uio_out, 8'h01);

    // progEn during operation mutes outputs; idle progClk leaves config intact.
    ui_in[2] = 1'b1;
    tick(3);
    check8("en_mute_out", uio_out, 8'h00);
    check8("en_mute_oe", uio_oe, 8'h00);
    readback(rb);
    check_cfg("en_cfg_kept", rb, tog_cfg);

    // progClk held high for 20 cycles shifts exactly once.
    ui_in[1] = 1'b1;
    tick(1);
    ui_in[1] = 1'b0;
    ui_in[2] = 1'b1;
    ui_in[3] = 1'b1;
    ui_in[0] = 1'b1;
    tick(20);
    ui_in[0] = 1'b0;
    ui_in[3] = 1'b0;
    tick(2);
    readback(rb);
    exp_cfg = '0;
    exp_cfg[CW-1] = 1'b1;
    check_cfg("held_clk_one_shift", rb, exp_cfg);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
